// File: rtl/fpd_arbiter.sv
// Round-robin arbiter sharing one floating-point divider among N_REQ requesters.
// Define FPD_ARB_TIMEOUT_EN to enable the WAIT-state watchdog abort.
module fpd_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned W  = 1 + EXP_WIDTH + MANTISSA_WIDTH,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_a_i,
  input  logic [N_REQ*W-1:0] req_b_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  input  logic [N_REQ-1:0]   rsp_ready_i,
  output logic [W-1:0]       rsp_result_o,
  output logic               rsp_overflow_o,
  output logic               rsp_underflow_o,
  output logic               rsp_error_o,
  output logic               fpd_start_o,
  output logic [W-1:0]       fpd_a_o,
  output logic [W-1:0]       fpd_b_o,
  input  logic               fpd_done_i,
  input  logic [W-1:0]       fpd_result_i,
  input  logic               fpd_overflow_i,
  input  logic               fpd_underflow_i,
  output logic               busy_o,
  output logic [IW-1:0]      grant_id_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_last_grant;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic            r_ovf;
  logic            r_unf;
  logic            r_err;
  logic            w_found;
  logic [IW-1:0]   w_grant;
  logic [IW-1:0]   w_idx;
  logic [N_REQ-1:0] w_req_ready;
  logic            w_timeout;

  // State register; reset wins over any in-flight divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round-robin pick starting after the last completed grant, plus next-state.
  always_comb begin
    w_next      = r_state;
    w_found     = 1'b0;
    w_grant     = r_last_grant;
    w_idx       = r_last_grant;
    w_req_ready = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      w_idx = IW'((int'(r_last_grant) + i) % int'(N_REQ));
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
    case (r_state)
      S_IDLE: begin
        if (w_found && !reset) begin
          w_req_ready[w_grant] = 1'b1;
          w_next               = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (fpd_done_i || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i[r_grant]) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, result capture and grant bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= '0;
      r_last_grant <= IW'(N_REQ - 1);
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_grant;
            r_a     <= req_a_i[w_grant*W +: W];
            r_b     <= req_b_i[w_grant*W +: W];
          end
        end
        S_WAIT: begin
          if (fpd_done_i) begin
            r_result <= fpd_result_i;
            r_ovf    <= fpd_overflow_i;
            r_unf    <= fpd_underflow_i;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i[r_grant]) begin
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FPD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wd_cnt;

  // Watchdog counts WAIT cycles; cleared on the ISSUE->WAIT transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    rsp_valid_o = '0;
    if (r_state == S_RESP) begin
      rsp_valid_o[r_grant] = 1'b1;
    end
  end

  assign req_ready_o     = w_req_ready;
  assign rsp_result_o    = r_result;
  assign rsp_overflow_o  = r_ovf;
  assign rsp_underflow_o = r_unf;
  assign rsp_error_o     = r_err;
  assign fpd_start_o     = (r_state == S_ISSUE);
  assign fpd_a_o         = r_a;
  assign fpd_b_o         = r_b;
  assign busy_o          = (r_state != S_IDLE);
  assign grant_id_o      = r_grant;

endmodule

// File: tb/tb_fpd_arbiter.sv
// Directed self-checking bench for fpd_arbiter; the bench drives the divider side by hand.
// Watchdog scenarios follow FPD_ARB_TIMEOUT_EN.
module tb_fpd_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*W-1:0]   req_a_i, req_b_i;
  logic [W-1:0]     rsp_result_o, fpd_a_o, fpd_b_o, fpd_result_i;
  logic             rsp_overflow_o, rsp_underflow_o, rsp_error_o, fpd_start_o;
  logic             fpd_done_i, fpd_overflow_i, fpd_underflow_i, busy_o;
  logic [IW-1:0]    grant_id_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpd_arbiter #(.N_REQ(4), .EXP_WIDTH(8), .MANTISSA_WIDTH(23), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_overflow_o(rsp_overflow_o),
    .rsp_underflow_o(rsp_underflow_o), .rsp_error_o(rsp_error_o),
    .fpd_start_o(fpd_start_o), .fpd_a_o(fpd_a_o), .fpd_b_o(fpd_b_o),
    .fpd_done_i(fpd_done_i), .fpd_result_i(fpd_result_i),
    .fpd_overflow_i(fpd_overflow_i), .fpd_underflow_i(fpd_underflow_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_valid_i = '0; rsp_ready_i = '0; req_a_i = '0; req_b_i = '0;
    fpd_done_i = 1'b0; fpd_result_i = '0; fpd_overflow_i = 1'b0; fpd_underflow_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    total++; if (req_ready_o !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); end
    total++; if (rsp_valid_o !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); end
    total++; if (rsp_result_o !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", rsp_result_o); end
    total++; if ({rsp_overflow_o, rsp_underflow_o, rsp_error_o} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {rsp_overflow_o, rsp_underflow_o, rsp_error_o}); end
    total++; if (fpd_start_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL reset_start_busy: got %b%b want 00", fpd_start_o, busy_o); end
    total++; if (fpd_a_o !== 32'h0 || fpd_b_o !== 32'h0) begin bad++; $display("FAIL reset_operands: got %h %h want 0 0", fpd_a_o, fpd_b_o); end
    total++; if (grant_id_o !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id_o); end
    reset = 1'b0;
  endtask

  task automatic test_basic_latency();
    int starts;
    int early;
    do_reset();
    req_a_i[0 +: W] = 32'h3F800000;
    req_b_i[0 +: W] = 32'h40000000;
    req_valid_i = 4'b0001;
    #1;
    total++; if (req_ready_o !== 4'b0001) begin bad++; $display("FAIL basic_accept: got %b want 0001", req_ready_o); end
    tick();
    req_valid_i = '0;
    total++; if (fpd_start_o !== 1'b1) begin bad++; $display("FAIL basic_start_c1: got %b want 1", fpd_start_o); end
    total++; if (fpd_a_o !== 32'h3F800000 || fpd_b_o !== 32'h40000000) begin bad++; $display("FAIL basic_operands: got %h %h want 3f800000 40000000", fpd_a_o, fpd_b_o); end
    starts = 0;
    early  = 0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (fpd_start_o) starts++;
      if (rsp_valid_o != 4'b0000) early++;
      if (c == 6) begin fpd_done_i = 1'b1; fpd_result_i = 32'h3F000000; end
    end
    tick();
    fpd_done_i = 1'b0;
    fpd_result_i = 32'hDEADBEEF;
    total++; if (starts != 0 || early != 0) begin bad++; $display("FAIL basic_pulse_shape: got extra_starts=%0d early_valid=%0d want 0 0", starts, early); end
    total++; if (rsp_valid_o !== 4'b0001) begin bad++; $display("FAIL basic_rsp_valid_c7: got %b want 0001", rsp_valid_o); end
    total++; if (rsp_result_o !== 32'h3F000000) begin bad++; $display("FAIL basic_result: got %h want 3f000000", rsp_result_o); end
    rsp_ready_i = 4'b1110;
    tick();
    total++; if (rsp_valid_o !== 4'b0001 || rsp_result_o !== 32'h3F000000) begin bad++; $display("FAIL basic_other_ready_ignored: got %b %h want 0001 3f000000", rsp_valid_o, rsp_result_o); end
    rsp_ready_i = 4'b0001;
    tick();
    rsp_ready_i = '0;
    total++; if (busy_o !== 1'b0 || rsp_valid_o !== 4'b0000) begin bad++; $display("FAIL basic_release: got busy=%b valid=%b want 0 0000", busy_o, rsp_valid_o); end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int k;
    int multi;
    logic pend;
    do_reset();
    req_valid_i = 4'b1111;
    rsp_ready_i = 4'b1111;
    k = 0;
    multi = 0;
    pend = 1'b0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      #1;
      if ($countones(req_ready_o) > 1) multi++;
      tick();
      fpd_done_i = pend;
      pend = fpd_start_o;
      if (fpd_start_o) begin
        total++; if (int'(grant_id_o) != exp_g[k]) begin bad++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, grant_id_o, exp_g[k]); end
        k++;
      end
    end
    total++; if (k != 5) begin bad++; $display("FAIL rr_grant_count: got %0d want 5", k); end
    total++; if (multi != 0) begin bad++; $display("FAIL rr_multi_hot_ready: got %0d cycles want 0", multi); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a_i[2*W +: W] = 32'h41200000;
    req_b_i[2*W +: W] = 32'h40A00000;
    req_valid_i = 4'b0100;
    rsp_ready_i = 4'b1011;
    #1;
    total++; if (req_ready_o !== 4'b0100) begin bad++; $display("FAIL bp_accept: got %b want 0100", req_ready_o); end
    tick();
    req_valid_i = 4'b1111;
    total++; if (grant_id_o !== 2'd2 || fpd_a_o !== 32'h41200000) begin bad++; $display("FAIL bp_grant: got %0d %h want 2 41200000", grant_id_o, fpd_a_o); end
    tick();
    fpd_done_i = 1'b1; fpd_result_i = 32'h12345678; fpd_underflow_i = 1'b1;
    tick();
    fpd_done_i = 1'b0; fpd_result_i = '0; fpd_underflow_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (rsp_valid_o !== 4'b0100 || rsp_result_o !== 32'h12345678 || rsp_underflow_o !== 1'b1 || req_ready_o !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b result=%h unf=%b ready=%b want 0100 12345678 1 0000", c, rsp_valid_o, rsp_result_o, rsp_underflow_o, req_ready_o);
      end
      tick();
    end
    rsp_ready_i = 4'b0100;
    tick();
    #1;
    total++; if (busy_o !== 1'b0 || req_ready_o !== 4'b1000) begin bad++; $display("FAIL bp_next_rr: got busy=%b ready=%b want 0 1000", busy_o, req_ready_o); end
    idle_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    req_a_i[1*W +: W] = 32'h7F000000;
    req_b_i[1*W +: W] = 32'h00800000;
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    tick();
    fpd_done_i = 1'b1; fpd_result_i = 32'h7F800000; fpd_overflow_i = 1'b1;
    tick();
    fpd_done_i = 1'b0; fpd_overflow_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b0010) begin bad++; $display("FAIL ovf_valid: got %b want 0010", rsp_valid_o); end
    total++; if (rsp_overflow_o !== 1'b1 || rsp_underflow_o !== 1'b0 || rsp_error_o !== 1'b0) begin bad++; $display("FAIL ovf_flags: got ovf=%b unf=%b err=%b want 1 0 0", rsp_overflow_o, rsp_underflow_o, rsp_error_o); end
    total++; if (rsp_result_o !== 32'h7F800000) begin bad++; $display("FAIL ovf_result: got %h want 7f800000", rsp_result_o); end
    rsp_ready_i = 4'b0010;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    req_a_i[0 +: W] = 32'h40400000;
    req_b_i[0 +: W] = 32'h3F800000;
    req_a_i[3*W +: W] = 32'h40800000;
    req_b_i[3*W +: W] = 32'h40000000;
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0 || fpd_start_o !== 1'b0 || rsp_valid_o !== 4'b0000 || req_ready_o !== 4'b0000) begin bad++; $display("FAIL midrst_ctrl: got busy=%b start=%b valid=%b ready=%b want 0 0 0000 0000", busy_o, fpd_start_o, rsp_valid_o, req_ready_o); end
    total++; if (fpd_a_o !== 32'h0 || fpd_b_o !== 32'h0 || grant_id_o !== 2'd0) begin bad++; $display("FAIL midrst_regs: got a=%h b=%h grant=%0d want 0 0 0", fpd_a_o, fpd_b_o, grant_id_o); end
    reset = 1'b0;
    fpd_done_i = 1'b1; fpd_result_i = 32'h11111111; fpd_overflow_i = 1'b1;
    tick();
    fpd_done_i = 1'b0; fpd_result_i = '0; fpd_overflow_i = 1'b0;
    tick();
    total++; if (busy_o !== 1'b0 || rsp_valid_o !== 4'b0000 || rsp_result_o !== 32'h0 || rsp_overflow_o !== 1'b0) begin bad++; $display("FAIL midrst_stray_done: got busy=%b valid=%b result=%h ovf=%b want 0 0000 0 0", busy_o, rsp_valid_o, rsp_result_o, rsp_overflow_o); end
    req_valid_i = 4'b1000;
    #1;
    total++; if (req_ready_o !== 4'b1000) begin bad++; $display("FAIL midrst_req3_ready: got %b want 1000", req_ready_o); end
    tick();
    req_valid_i = '0;
    total++; if (grant_id_o !== 2'd3 || fpd_a_o !== 32'h40800000) begin bad++; $display("FAIL midrst_req3_grant: got %0d %h want 3 40800000", grant_id_o, fpd_a_o); end
    tick();
    fpd_done_i = 1'b1; fpd_result_i = 32'h40000000;
    tick();
    fpd_done_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b1000 || rsp_result_o !== 32'h40000000) begin bad++; $display("FAIL midrst_req3_rsp: got %b %h want 1000 40000000", rsp_valid_o, rsp_result_o); end
    rsp_ready_i = 4'b1000;
    tick();
    idle_inputs();
  endtask

  task automatic test_watchdog();
    int cnt;
    do_reset();
    req_a_i[0 +: W] = 32'h3F800000;
    req_b_i[0 +: W] = 32'h40000000;
    req_a_i[1*W +: W] = 32'h3F800000;
    req_b_i[1*W +: W] = 32'h40800000;
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
`ifdef FPD_ARB_TIMEOUT_EN
    cnt = 1;
    while (rsp_valid_o == 4'b0000 && cnt < 200) begin
      tick();
      cnt++;
    end
    total++; if (cnt != 66) begin bad++; $display("FAIL wd_timeout_cycle: got %0d want 66", cnt); end
    total++; if (rsp_valid_o !== 4'b0001 || rsp_error_o !== 1'b1 || rsp_result_o !== 32'h0) begin bad++; $display("FAIL wd_error_rsp: got valid=%b err=%b result=%h want 0001 1 0", rsp_valid_o, rsp_error_o, rsp_result_o); end
    total++; if (rsp_overflow_o !== 1'b0 || rsp_underflow_o !== 1'b0) begin bad++; $display("FAIL wd_error_flags: got %b%b want 00", rsp_overflow_o, rsp_underflow_o); end
    rsp_ready_i = 4'b0001;
    tick();
    rsp_ready_i = '0;
    fpd_done_i = 1'b1; fpd_result_i = 32'h3F000000;
    tick();
    fpd_done_i = 1'b0;
    tick();
    total++; if (busy_o !== 1'b0 || rsp_valid_o !== 4'b0000) begin bad++; $display("FAIL wd_stray_done: got busy=%b valid=%b want 0 0000", busy_o, rsp_valid_o); end
    // Done arriving on the final watchdog cycle must win over the abort.
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    for (int c = 2; c <= 65; c++) begin
      tick();
      if (c == 65) begin fpd_done_i = 1'b1; fpd_result_i = 32'h3E800000; end
    end
    tick();
    fpd_done_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b0010 || rsp_error_o !== 1'b0 || rsp_result_o !== 32'h3E800000) begin bad++; $display("FAIL wd_done_wins: got valid=%b err=%b result=%h want 0010 0 3e800000", rsp_valid_o, rsp_error_o, rsp_result_o); end
`else
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy_o !== 1'b1 || rsp_valid_o !== 4'b0000 || rsp_error_o !== 1'b0) cnt++;
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL nowd_long_wait: got %0d bad cycles want 0", cnt); end
    fpd_done_i = 1'b1; fpd_result_i = 32'h3F000000;
    tick();
    fpd_done_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b0001 || rsp_error_o !== 1'b0 || rsp_result_o !== 32'h3F000000) begin bad++; $display("FAIL nowd_rsp: got valid=%b err=%b result=%h want 0001 0 3f000000", rsp_valid_o, rsp_error_o, rsp_result_o); end
`endif
    rsp_ready_i = 4'b1111;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic_latency();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid_divide();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
